// File: rtl/tx_ramp_dac.sv
// TX gain ramp in front of the DAC: raises or lowers a gain in steps on PTT,
// then multiplies, rounds and saturates the mixer sample to 12 bits.
module tx_ramp_dac #(
    parameter int unsigned RAMP_LOG2 = 10,
    parameter int unsigned STEP_DIV  = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ptt_in,
    input  logic [12:0] i_in,
    output logic [11:0] dac_data,
    output logic        clip,
    output logic        tx_active,
    output logic        tx_full
);

    localparam int unsigned GW = RAMP_LOG2 + 1;
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 13 + RAMP_LOG2 + 1;

    localparam logic [GW-1:0]        G_FULL   = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [CW-1:0]        CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic signed [PW:0]   HALF     = (PW+1)'(1) << (RAMP_LOG2 - 1);
    localparam logic signed [PW:0]   DAC_MAX  = (PW+1)'(2047);
    localparam logic signed [PW:0]   DAC_MIN  = (PW+1)'(-2048);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [GW-1:0]  g, g_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           tick;

    logic signed [PW-1:0] prod;
    logic signed [PW:0]   sum_c;
    logic signed [PW:0]   rnd_c;
    logic [11:0]          dac_c;
    logic                 clip_c;
    logic                 act_d1;
    logic                 full_d1;

    // State, gain and prescaler registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            g     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; a PTT direction change wins over a coincident step tick
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        cnt_nxt   = '0;
        tick      = (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                g_nxt = '0;
                if (ptt_in) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                cnt_nxt = tick ? '0 : cnt + CW'(1);
                if (!ptt_in) begin
                    state_nxt = RAMP_DOWN;
                end else if (tick) begin
                    if (g >= G_FULL - GW'(1)) begin
                        g_nxt     = G_FULL;
                        state_nxt = ON;
                    end else begin
                        g_nxt = g + GW'(1);
                    end
                end
            end
            ON: begin
                g_nxt = G_FULL;
                if (!ptt_in) state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                cnt_nxt = tick ? '0 : cnt + CW'(1);
                if (ptt_in) begin
                    state_nxt = RAMP_UP;
                end else if (tick) begin
                    // g <= 1 also covers a reversal taken while g was still 0
                    if (g <= GW'(1)) begin
                        g_nxt     = '0;
                        state_nxt = IDLE;
                    end else begin
                        g_nxt = g - GW'(1);
                    end
                end
            end
            default: begin
                g_nxt     = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Round half up, then clamp to the 12-bit DAC range
    always_comb begin
        sum_c  = (PW+1)'(prod) + HALF;
        rnd_c  = sum_c >>> RAMP_LOG2;
        dac_c  = rnd_c[11:0];
        clip_c = 1'b0;
        if (rnd_c > DAC_MAX) begin
            dac_c  = 12'h7FF;
            clip_c = 1'b1;
        end else if (rnd_c < DAC_MIN) begin
            dac_c  = 12'h800;
            clip_c = 1'b1;
        end
    end

    // Two-stage datapath with state decodes delayed to match
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod      <= '0;
            act_d1    <= 1'b0;
            full_d1   <= 1'b0;
            dac_data  <= '0;
            clip      <= 1'b0;
            tx_active <= 1'b0;
            tx_full   <= 1'b0;
        end else begin
            prod      <= PW'($signed(i_in)) * $signed(PW'({1'b0, g}));
            act_d1    <= (state != IDLE);
            full_d1   <= (state == ON);
            dac_data  <= dac_c;
            clip      <= clip_c;
            tx_active <= act_d1;
            tx_full   <= full_d1;
        end
    end

endmodule
